// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, FSM encoding
// and the grant decision helper used when both ports are waiting.
package vram_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Display wins ties unless the CPU has been starved for too long.
  function automatic logic pick_cpu(input logic disp_pend,
                                    input logic cpu_pend,
                                    input logic starved);
    return cpu_pend && (!disp_pend || starved);
  endfunction

endpackage

// File: rtl/vram_req_slot.sv
// One-deep pending request holder: captures a request pulse and its payload.
// A pulse arriving in the same cycle as clear refills the freed slot.
// A pulse arriving while the slot is occupied (and not clearing) is dropped.
module vram_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] data,
  input  logic         clear,
  output logic         pending,
  output logic [W-1:0] held
);

  // Load on a free (or freeing) slot, otherwise drop pending on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      held    <= '0;
    end else if (req && (!pending || clear)) begin
      pending <= 1'b1;
      held    <= data;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates display reads and CPU reads/writes onto a single-port VRAM.
// Idle-path latency: request sampled at edge N, ready pulse in cycle N+3.
// Each port holds one pending request; display has priority with CPU anti-starvation.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_overrun
);

  localparam int CNT_W   = $clog2(STARVE_MAX + 1);
  localparam int CPU_W   = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t state, next_state;

  logic              disp_pend, cpu_pend;
  logic [ADDR_W-1:0] disp_slot_addr;
  logic [CPU_W-1:0]  cpu_slot;
  logic              cpu_slot_we;
  logic [ADDR_W-1:0] cpu_slot_addr;
  logic [DATA_W-1:0] cpu_slot_wdata;

  logic             grant_cpu;      // port owning the access in flight
  logic [CNT_W-1:0] cpu_wait_cnt;
  logic             starved;

  logic              start, finish, grant_sel;
  logic              disp_clear, cpu_clear;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  vram_req_slot #(.W(ADDR_W)) u_disp_slot (
    .clk     (clk),
    .reset   (reset),
    .req     (disp_req),
    .data    (disp_addr),
    .clear   (disp_clear),
    .pending (disp_pend),
    .held    (disp_slot_addr)
  );

  vram_req_slot #(.W(CPU_W)) u_cpu_slot (
    .clk     (clk),
    .reset   (reset),
    .req     (cpu_req),
    .data    ({cpu_we, cpu_addr, cpu_wdata}),
    .clear   (cpu_clear),
    .pending (cpu_pend),
    .held    (cpu_slot)
  );

  assign cpu_slot_we    = cpu_slot[CPU_W-1];
  assign cpu_slot_addr  = cpu_slot[DATA_W +: ADDR_W];
  assign cpu_slot_wdata = cpu_slot[DATA_W-1:0];
  assign starved        = (cpu_wait_cnt >= CNT_MAX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: leave IDLE whenever work is pending, rest is fixed.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE:     next_state = (disp_pend || cpu_pend) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:    next_state = ST_COMPLETE;
      ST_COMPLETE: next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Output decode: grant choice and the values the mem_* flops load next.
  always_comb begin
    start       = (state == ST_IDLE) && (disp_pend || cpu_pend);
    finish      = (state == ST_COMPLETE);
    grant_sel   = pick_cpu(disp_pend, cpu_pend, starved);
    disp_clear  = finish && !grant_cpu;
    cpu_clear   = finish && grant_cpu;
    mem_en_d    = start;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (start) begin
      if (grant_sel) begin
        mem_we_d    = cpu_slot_we;
        mem_addr_d  = cpu_slot_addr;
        mem_wdata_d = cpu_slot_wdata;
      end else begin
        mem_addr_d  = disp_slot_addr;
      end
    end
  end

  // Registered RAM interface, active only during ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Remember which port owns the access until it completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      grant_cpu <= 1'b0;
    else if (start) grant_cpu <= grant_sel;
  end

  // Count display wins over a waiting CPU; saturates, cleared by a CPU grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_wait_cnt <= '0;
    end else if (start) begin
      if (grant_sel)                           cpu_wait_cnt <= '0;
      else if (cpu_pend && (cpu_wait_cnt != CNT_MAX)) cpu_wait_cnt <= cpu_wait_cnt + 1'b1;
    end
  end

  // Completion: capture read data for the owning port and pulse its ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_ready <= 1'b0;
      cpu_ready  <= 1'b0;
      disp_data  <= '0;
      cpu_rdata  <= '0;
    end else begin
      disp_ready <= disp_clear;
      cpu_ready  <= cpu_clear;
      if (disp_clear) disp_data <= mem_rdata;
      if (cpu_clear)  cpu_rdata <= mem_rdata;
    end
  end

  // Sticky flag for a display request dropped because its slot was busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) disp_overrun <= 1'b0;
    else if (disp_req && disp_pend && !disp_clear) disp_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic [31:0] disp_data;
  logic        disp_ready;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        disp_overrun;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [31:0] ram [0:32767];

  vram_arbiter #(.ADDR_W(15), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .disp_ready   (disp_ready),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .disp_overrun (disp_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // RAM: read data appears one clock after the enabled edge (read-before-write).
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic        seen;
  logic [31:0] dmask, cmask, last_disp;
  int          nready;

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 32'hA500_0000 | i;
    ram[15'h0123] = 32'hDEAD_BEEF;
    mem_rdata = '0;

    // Reset, with a request pulse that must be ignored.
    reset = 1'b1; disp_req = 1'b1; disp_addr = 15'h0077;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_disp_ready", disp_ready, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_overrun", disp_overrun, 0);
    disp_req = 1'b0; reset = 1'b0;
    seen = 1'b0;
    while (edge_cnt < 9) begin
      tick();
      seen = seen | mem_en | disp_ready;
    end
    chk("rst_req_ignored", seen, 0);

    // Display read sampled at edge 10.
    disp_req = 1'b1; disp_addr = 15'h0123;
    tick(); disp_req = 1'b0;
    chk("d_edge10", edge_cnt, 10);
    chk("d_pre_mem_en", mem_en, 0);
    tick();
    chk("d_c11_mem_en", mem_en, 1);
    chk("d_c11_mem_addr", mem_addr, 15'h0123);
    chk("d_c11_mem_we", mem_we, 0);
    tick();
    chk("d_c12_mem_en", mem_en, 0);
    chk("d_c12_ready", disp_ready, 0);
    tick();
    chk("d_c13_ready", disp_ready, 1);
    chk("d_c13_data", disp_data, 32'hDEAD_BEEF);
    chk("d_c13_cpu_ready", cpu_ready, 0);
    tick();
    chk("d_c14_ready", disp_ready, 0);
    chk("d_c14_hold", disp_data, 32'hDEAD_BEEF);

    // CPU write then read back at the top address.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7FFF; cpu_wdata = 32'h5A5A_5A5A;
    tick(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    chk("w_n_mem_we", mem_we, 0);
    tick();
    chk("w_issue_en", mem_en, 1);
    chk("w_issue_we", mem_we, 1);
    chk("w_issue_addr", mem_addr, 15'h7FFF);
    chk("w_issue_wdata", mem_wdata, 32'h5A5A_5A5A);
    tick();
    chk("w_complete_we", mem_we, 0);
    chk("w_complete_wdata", mem_wdata, 0);
    tick();
    chk("w_ready", cpu_ready, 1);
    tick();
    chk("w_ready_pulse", cpu_ready, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
    tick(); cpu_req = 1'b0;
    tick();
    chk("r_issue_en", mem_en, 1);
    chk("r_issue_we", mem_we, 0);
    tick(); tick();
    chk("r_ready", cpu_ready, 1);
    chk("r_rdata", cpu_rdata, 32'h5A5A_5A5A);
    chk("r_disp_hold", disp_data, 32'hDEAD_BEEF);
    tick();

    // Simultaneous requests: display first, CPU three clocks later.
    disp_req = 1'b1; disp_addr = 15'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0300;
    tick(); disp_req = 1'b0; cpu_req = 1'b0;
    tick();
    chk("both_first_addr", mem_addr, 15'h0200);
    tick(); tick();
    chk("both_disp_ready", disp_ready, 1);
    chk("both_disp_data", disp_data, 32'hA500_0200);
    chk("both_cpu_not_yet", cpu_ready, 0);
    tick();
    chk("both_second_en", mem_en, 1);
    chk("both_second_addr", mem_addr, 15'h0300);
    tick(); tick();
    chk("both_cpu_ready", cpu_ready, 1);
    chk("both_cpu_rdata", cpu_rdata, 32'hA500_0300);
    chk("both_cpu_disp_ready", disp_ready, 0);
    tick();

    // CPU pending under back-to-back display traffic.
    dmask = '0; cmask = '0; last_disp = '0;
    for (int r = 0; r <= 20; r++) begin
      disp_req  = (r % 3 == 0) && (r <= 12);
      disp_addr = 15'(16 + r / 3);
      cpu_req   = (r == 0);
      cpu_we    = 1'b0;
      cpu_addr  = 15'h0400;
      tick();
      if (disp_ready) begin dmask[r] = 1'b1; last_disp = disp_data; end
      if (cpu_ready)  cmask[r] = 1'b1;
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    chk("starve_disp_mask", dmask, 32'h0004_1248);
    chk("starve_cpu_mask", cmask, 32'h0000_8000);
    chk("starve_cpu_rdata", cpu_rdata, 32'hA500_0400);
    chk("starve_last_disp", last_disp, 32'hA500_0014);
    chk("starve_no_overrun", disp_overrun, 0);
    tick();

    // Second display request one cycle after the first is dropped.
    dmask = '0; nready = 0; last_disp = '0;
    for (int r = 0; r <= 7; r++) begin
      disp_req  = (r <= 1);
      disp_addr = (r == 0) ? 15'h0030 : 15'h0031;
      tick();
      if (r == 0) chk("ovr_not_yet", disp_overrun, 0);
      if (r == 1) chk("ovr_set", disp_overrun, 1);
      if (disp_ready) begin dmask[r] = 1'b1; nready++; last_disp = disp_data; end
    end
    disp_req = 1'b0;
    chk("ovr_ready_count", nready, 1);
    chk("ovr_ready_mask", dmask, 32'h0000_0008);
    chk("ovr_first_addr_data", last_disp, 32'hA500_0030);
    chk("ovr_sticky", disp_overrun, 1);

    // Reset during ISSUE of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0050; cpu_wdata = 32'h1111_2222;
    tick(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    tick();
    chk("mid_issue_en", mem_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_overrun", disp_overrun, 0);
    chk("mid_rst_disp_data", disp_data, 0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 0);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int r = 0; r < 6; r++) begin
      tick();
      seen = seen | disp_ready | cpu_ready | mem_en;
    end
    chk("mid_rst_no_activity", seen, 0);
    disp_req = 1'b1; disp_addr = 15'h0050;
    tick(); disp_req = 1'b0;
    tick();
    chk("post_rst_issue_addr", mem_addr, 15'h0050);
    tick(); tick();
    chk("post_rst_ready", disp_ready, 1);
    chk("post_rst_data", disp_data, 32'hA500_0050);
    chk("post_rst_cpu_ready", cpu_ready, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
